// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU among NUM_REQ requesters, one op in flight at a time.
// Legal ops respond 3 cycles after accept and illegal ops after 1; the response holds until resp_ready, with no grants meanwhile.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_result,
  output logic                    resp_zero,
  output logic                    resp_overflow,
  output logic                    resp_illegal,
  output logic                    busy,
  output logic [2:0]              alu_control,
  output logic [31:0]             alu_src_a,
  output logic [31:0]             alu_src_b,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_overflow
);

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [ID_W-1:0] id;
  } req_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic            grant_vld;
  req_t            grant_req;

  function automatic logic op_legal(input logic [2:0] op);
    return (op != 3'b011) && (op != 3'b100);
  endfunction

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_req = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld    = 1'b1;
        grant_req.op = req_op[3*idx +: 3];
        grant_req.a  = req_a[32*idx +: 32];
        grant_req.b  = req_b[32*idx +: 32];
        grant_req.id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (grant_vld && !reset) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (grant_req.id == ID_W'(i));
          end
        end
        if (grant_vld) begin
          state_nxt = op_legal(grant_req.op) ? ISSUE : RESP;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr        <= '0;
      alu_control   <= '0;
      alu_src_a     <= '0;
      alu_src_b     <= '0;
      resp_id       <= '0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_illegal  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            resp_id <= grant_req.id;
            // Illegal ops never reach the ALU, so its inputs keep the previous op.
            if (op_legal(grant_req.op)) begin
              alu_control <= grant_req.op;
              alu_src_a   <= grant_req.a;
              alu_src_b   <= grant_req.b;
            end else begin
              resp_result   <= '0;
              resp_zero     <= 1'b0;
              resp_overflow <= 1'b0;
              resp_illegal  <= 1'b1;
            end
          end
        end
        WAIT: begin
          resp_result   <= alu_result;
          resp_zero     <= alu_zero;
          // The ALU leaves overflow stale for logic ops.
          resp_overflow <= ((alu_control == OP_ADD) || (alu_control == OP_SUB)) && alu_overflow;
          resp_illegal  <= 1'b0;
        end
        RESP: begin
          if (resp_ready) begin
            rr_ptr <= (resp_id == ID_W'(NUM_REQ-1)) ? '0 : resp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a cycle-level reference model of grants, latency and responses.
module tb_alu_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_op = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_result;
  logic            resp_zero;
  logic            resp_overflow;
  logic            resp_illegal;
  logic            busy;
  logic [2:0]      alu_control;
  logic [31:0]     alu_src_a;
  logic [31:0]     alu_src_b;
  logic [31:0]     alu_result = '0;
  logic            alu_zero = 1'b0;
  logic            alu_overflow = 1'b0;

  alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_overflow(resp_overflow), .resp_illegal(resp_illegal), .busy(busy),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b101:  return a ^ b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Overflow from exact 64-bit arithmetic; logic ops report a deliberately stale 1.
  function automatic logic alu_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'b010) r = sa + sb;
    else if (op == 3'b110) r = sa - sb;
    else return 1'b1;
    return r != longint'($signed(r[31:0]));
  endfunction

  // Registered ALU stand-in.
  always @(posedge clock) begin
    alu_result   <= alu_res(alu_control, alu_src_a, alu_src_b);
    alu_zero     <= (alu_res(alu_control, alu_src_a, alu_src_b) == 32'd0);
    alu_overflow <= alu_ovf(alu_control, alu_src_a, alu_src_b);
  end

  typedef struct packed {
    logic        ill;
    logic        ovf;
    logic        zero;
    logic [31:0] res;
  } exp_t;

  function automatic exp_t ref_resp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (op == 3'b011 || op == 3'b100) begin
      e = '{ill: 1'b1, ovf: 1'b0, zero: 1'b0, res: 32'd0};
    end else begin
      e.ill  = 1'b0;
      e.res  = alu_res(op, a, b);
      e.zero = (e.res == 32'd0);
      e.ovf  = (op == 3'b010 || op == 3'b110) ? alu_ovf(op, a, b) : 1'b0;
    end
    return e;
  endfunction

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Requester side and model state.
  logic [N-1:0] pend = '0;
  logic [2:0]   p_op [N];
  logic [31:0]  p_a  [N];
  logic [31:0]  p_b  [N];
  bit           rst_drv = 1'b1;
  bit           post_reset = 1'b0;
  bit           refill = 1'b0;
  int           rdy_mode = 0;
  int           rv_cnt = 0;
  bit           inflight = 1'b0;
  int           age = 0;
  int           lat = 3;
  int           exp_id = 0;
  exp_t         exp_resp = '0;
  int           rr = 0;
  logic [2:0]   ea_ctl = '0;
  logic [31:0]  ea_a = '0;
  logic [31:0]  ea_b = '0;
  int           gl[$];
  logic [31:0]  last_res = '0;
  logic         last_zero = 1'b0, last_ovf = 1'b0, last_ill = 1'b0;
  logic [IW-1:0] last_id = '0;

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  task automatic new_req(input int i);
    set_req(i, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int g, idx;
    bit exp_rv;
    @(negedge clock);
    reset = rst_drv;
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = pend[i];
      req_op[3*i +: 3]  = p_op[i];
      req_a[32*i +: 32] = p_a[i];
      req_b[32*i +: 32] = p_b[i];
    end
    exp_rv = inflight && (age >= lat);
    case (rdy_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'($urandom_range(0, 1));
      default: resp_ready = (rv_cnt >= 5);
    endcase
    #1;
    if (rst_drv) begin
      chk("rst_req_ready", req_ready, '0);
      inflight = 1'b0; rr = 0; rv_cnt = 0; post_reset = 1'b1;
      ea_ctl = '0; ea_a = '0; ea_b = '0;
      return;
    end
    if (post_reset) begin
      chk("rst_resp_result", resp_result, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_flags", {resp_zero, resp_overflow, resp_illegal}, 0);
      post_reset = 1'b0;
    end
    chk("busy", busy, inflight);
    chk("alu_control", alu_control, ea_ctl);
    chk("alu_src_a", alu_src_a, ea_a);
    chk("alu_src_b", alu_src_b, ea_b);
    chk("resp_valid", resp_valid, exp_rv);
    if (exp_rv) begin
      chk("resp_id", resp_id, exp_id);
      chk("resp_result", resp_result, exp_resp.res);
      chk("resp_zero", resp_zero, exp_resp.zero);
      chk("resp_overflow", resp_overflow, exp_resp.ovf);
      chk("resp_illegal", resp_illegal, exp_resp.ill);
    end
    exp_rdy = '0;
    g = -1;
    if (!inflight) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (inflight) begin
      if (exp_rv) begin
        rv_cnt++;
        if (resp_ready) begin
          last_res = resp_result; last_zero = resp_zero; last_ovf = resp_overflow;
          last_ill = resp_illegal; last_id = resp_id;
          inflight = 1'b0;
          rr = (exp_id + 1) % N;
          rv_cnt = 0;
        end
      end
      age++;
    end else if (g >= 0) begin
      gl.push_back(g);
      inflight = 1'b1;
      age      = 1;
      exp_id   = g;
      exp_resp = ref_resp(p_op[g], p_a[g], p_b[g]);
      lat      = exp_resp.ill ? 1 : 3;
      if (!exp_resp.ill) begin
        ea_ctl = p_op[g]; ea_a = p_a[g]; ea_b = p_b[g];
      end
      if (refill) new_req(g);
      else pend[g] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inflight || pend != '0) && n < 300) begin
      cycle();
      n++;
    end
    chk("drain_timeout", (n < 300), 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
    end
    rst_drv = 1'b1;
    cycle();
    cycle();
    rst_drv = 1'b0;

    // Single add.
    rdy_mode = 0;
    set_req(0, 3'b010, 32'd5, 32'd7);
    drain();
    chk("t1_result", last_res, 32'd12);
    chk("t1_id", last_id, 0);
    chk("t1_zero_ovf", {last_zero, last_ovf}, 2'b00);

    // Signed overflow, then a logic op whose stale overflow must be masked.
    set_req(0, 3'b110, 32'h8000_0000, 32'd1);
    drain();
    chk("t2_sub_result", last_res, 32'h7FFF_FFFF);
    chk("t2_sub_ovf", last_ovf, 1'b1);
    set_req(0, 3'b000, 32'd0, 32'd0);
    drain();
    chk("t2_and_result", last_res, 32'd0);
    chk("t2_and_zero_ovf", {last_zero, last_ovf}, 2'b10);

    // Fairness with two requesters always valid.
    rst_drv = 1'b1; cycle(); rst_drv = 1'b0;
    gl.delete();
    new_req(0);
    new_req(1);
    refill = 1'b1;
    n = 0;
    while (gl.size() < 6 && n < 200) begin cycle(); n++; end
    refill = 1'b0;
    drain();
    chk("t3_grant_count", (gl.size() >= 6), 1);
    for (int i = 0; i < 6 && i < gl.size(); i++) chk("t3_order", gl[i], i % 2);

    // Response backpressure for 5 cycles with another requester waiting.
    rdy_mode = 2;
    set_req(1, 3'b010, 32'h1234, 32'h1);
    set_req(0, 3'b101, 32'hF0F0_F0F0, 32'hFFFF_0000);
    drain();
    rdy_mode = 0;

    // Illegal ops respond quickly and leave the ALU inputs untouched.
    set_req(0, 3'b010, 32'd3, 32'd4);
    drain();
    set_req(0, 3'b011, 32'hAAAA_AAAA, 32'h5555_5555);
    drain();
    chk("t5_ill", last_ill, 1'b1);
    chk("t5_result", last_res, 32'd0);
    set_req(2, 3'b100, 32'h1, 32'h2);
    drain();
    chk("t5_ill2", last_ill, 1'b1);
    chk("t5_alu_a", alu_src_a, 32'd3);

    // Reset while the op waits on the ALU.
    set_req(0, 3'b010, 32'd1, 32'd2);
    n = 0;
    while (!(inflight && age == 2) && n < 50) begin cycle(); n++; end
    chk("t6_reach_wait", (n < 50), 1);
    rst_drv = 1'b1; cycle(); rst_drv = 1'b0;
    gl.delete();
    set_req(1, 3'b001, 32'h10, 32'h01);
    set_req(0, 3'b111, 32'hFFFF_FFFF, 32'd1);
    drain();
    chk("t6_grants", gl.size(), 2);
    if (gl.size() > 0) chk("t6_first_grant", gl[0], 0);

    // Random traffic with random response backpressure.
    rdy_mode = 1;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      end
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
